// File: rtl/tcm_pmem_axi_if.sv
// AXI4 bus bundle between the pmem burst initiator (master) and an AXI4 target (slave).
interface tcm_pmem_axi_if;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        rready;

    modport master (
        output awvalid, awaddr, awid, awlen, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rid, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arburst,
        output arready,
        output rvalid, rdata, rresp, rid, rlast,
        input  rready
    );
endinterface

// File: rtl/tcm_pmem_axi.sv
// pmem-style burst port to AXI4 INCR bursts, one transaction outstanding at a time.
// Optional TCM_PMEM_AXI_STATS_EN adds saturating W-beat / R-beat / error-response counters.
module tcm_pmem_axi #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  inport_wr_i,
    input  logic        inport_rd_i,
    input  logic [7:0]  inport_len_i,
    input  logic [31:0] inport_addr_i,
    input  logic [31:0] inport_write_data_i,
    output logic        inport_accept_o,
    output logic        inport_ack_o,
    output logic        inport_error_o,
    output logic [31:0] inport_read_data_o,
`ifdef TCM_PMEM_AXI_STATS_EN
    output logic [31:0] stat_wr_beats_o,
    output logic [31:0] stat_rd_beats_o,
    output logic [15:0] stat_err_o,
`endif
    tcm_pmem_axi_if.master axi
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT_B,
        ST_READ_AR,
        ST_READ_DATA
    } state_t;

    state_t      state_reg;
    logic [7:0]  cnt_reg;
    logic [31:0] addr_reg;
    logic [7:0]  len_reg;
    logic        awvalid_reg;
    logic        wvalid_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        wlast_reg;
    logic        w_done_reg;
    logic        arvalid_reg;
    logic        bready_reg;
    logic        rready_reg;

    logic w_hs;
    logic aw_hs;
    logic beat_slot;
    logic wr_beat;
    logic w_done_now;
    logic aw_done_now;
    logic b_hs;
    logic r_hs;

    assign w_hs        = wvalid_reg && axi.wready;
    assign aw_hs       = awvalid_reg && axi.awready;
    // cnt_reg counts beats still to be taken after the one in the W register,
    // so zero in WRITE means the whole burst has been accepted.
    assign beat_slot   = (state_reg == ST_WRITE) && (cnt_reg != 8'd0) && (!wvalid_reg || axi.wready);
    assign wr_beat     = beat_slot && (inport_wr_i != 4'd0);
    assign w_done_now  = w_done_reg || (w_hs && wlast_reg);
    assign aw_done_now = !awvalid_reg || axi.awready;
    assign b_hs        = bready_reg && axi.bvalid;
    assign r_hs        = rready_reg && axi.rvalid;

    always_comb begin
        inport_accept_o = 1'b0;
        case (state_reg)
            ST_IDLE:  inport_accept_o = 1'b1;
            ST_WRITE: inport_accept_o = beat_slot;
            default:  inport_accept_o = 1'b0;
        endcase
    end

    assign inport_ack_o       = b_hs || r_hs;
    assign inport_error_o     = (b_hs && (axi.bresp != 2'b00)) || (r_hs && (axi.rresp != 2'b00));
    assign inport_read_data_o = axi.rdata;

    assign axi.awvalid = awvalid_reg;
    assign axi.awaddr  = addr_reg;
    assign axi.awid    = AXI_ID;
    assign axi.awlen   = len_reg;
    assign axi.awburst = 2'b01;
    assign axi.wvalid  = wvalid_reg;
    assign axi.wdata   = wdata_reg;
    assign axi.wstrb   = wstrb_reg;
    assign axi.wlast   = wlast_reg;
    assign axi.bready  = bready_reg;
    assign axi.arvalid = arvalid_reg;
    assign axi.araddr  = addr_reg;
    assign axi.arid    = AXI_ID;
    assign axi.arlen   = len_reg;
    assign axi.arburst = 2'b01;
    assign axi.rready  = rready_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 8'd0;
            addr_reg    <= 32'd0;
            len_reg     <= 8'd0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            wdata_reg   <= 32'd0;
            wstrb_reg   <= 4'd0;
            wlast_reg   <= 1'b0;
            w_done_reg  <= 1'b0;
            arvalid_reg <= 1'b0;
            bready_reg  <= 1'b0;
            rready_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (inport_wr_i != 4'd0) begin
                        addr_reg    <= inport_addr_i;
                        len_reg     <= inport_len_i;
                        cnt_reg     <= inport_len_i;
                        awvalid_reg <= 1'b1;
                        wvalid_reg  <= 1'b1;
                        wdata_reg   <= inport_write_data_i;
                        wstrb_reg   <= inport_wr_i;
                        wlast_reg   <= (inport_len_i == 8'd0);
                        w_done_reg  <= 1'b0;
                        state_reg   <= ST_WRITE;
                    end else if (inport_rd_i) begin
                        addr_reg    <= inport_addr_i;
                        len_reg     <= inport_len_i;
                        cnt_reg     <= inport_len_i;
                        arvalid_reg <= 1'b1;
                        state_reg   <= ST_READ_AR;
                    end
                end
                ST_WRITE: begin
                    if (aw_hs) begin
                        awvalid_reg <= 1'b0;
                    end
                    if (wr_beat) begin
                        wvalid_reg <= 1'b1;
                        wdata_reg  <= inport_write_data_i;
                        wstrb_reg  <= inport_wr_i;
                        wlast_reg  <= (cnt_reg == 8'd1);
                        cnt_reg    <= cnt_reg - 8'd1;
                    end else if (w_hs) begin
                        wvalid_reg <= 1'b0;
                    end
                    if (w_hs && wlast_reg) begin
                        w_done_reg <= 1'b1;
                    end
                    // AW and the final W beat may complete in either order.
                    if (w_done_now && aw_done_now) begin
                        bready_reg <= 1'b1;
                        state_reg  <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (axi.bvalid) begin
                        bready_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end
                ST_READ_AR: begin
                    if (axi.arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= ST_READ_DATA;
                    end
                end
                ST_READ_DATA: begin
                    if (axi.rvalid) begin
                        if (cnt_reg == 8'd0) begin
                            rready_reg <= 1'b0;
                            state_reg  <= ST_IDLE;
                        end else begin
                            cnt_reg <= cnt_reg - 8'd1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef TCM_PMEM_AXI_STATS_EN
    logic [31:0] stat_wr_reg;
    logic [31:0] stat_rd_reg;
    logic [15:0] stat_err_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_wr_reg  <= 32'd0;
            stat_rd_reg  <= 32'd0;
            stat_err_reg <= 16'd0;
        end else begin
            if (w_hs && (stat_wr_reg != 32'hFFFF_FFFF)) begin
                stat_wr_reg <= stat_wr_reg + 32'd1;
            end
            if (r_hs && (stat_rd_reg != 32'hFFFF_FFFF)) begin
                stat_rd_reg <= stat_rd_reg + 32'd1;
            end
            if (inport_error_o && (stat_err_reg != 16'hFFFF)) begin
                stat_err_reg <= stat_err_reg + 16'd1;
            end
        end
    end

    assign stat_wr_beats_o = stat_wr_reg;
    assign stat_rd_beats_o = stat_rd_reg;
    assign stat_err_o      = stat_err_reg;
`endif

    // Response IDs are not checked; rlast only feeds the simulation check below.
    logic unused_resp_bits;
    assign unused_resp_bits = ^{axi.bid, axi.rid, axi.rlast};

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i && r_hs) begin
            assert (axi.rlast == (cnt_reg == 8'd0))
            else $error("tcm_pmem_axi: rlast out of step with beat count");
        end
    end
`endif

endmodule

// File: tb/tb_tcm_pmem_axi.sv
// Randomized scoreboard bench for tcm_pmem_axi with a behavioural AXI4 target model.
module tb_tcm_pmem_axi;
    localparam logic [3:0] TB_ID = 4'd5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  wr;
    logic        rd;
    logic [7:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        accept;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
`ifdef TCM_PMEM_AXI_STATS_EN
    logic [31:0] stat_wr;
    logic [31:0] stat_rd;
    logic [15:0] stat_err;
`endif

    tcm_pmem_axi_if axi ();

    tcm_pmem_axi #(.AXI_ID(TB_ID)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .inport_wr_i         (wr),
        .inport_rd_i         (rd),
        .inport_len_i        (len),
        .inport_addr_i       (addr),
        .inport_write_data_i (wdata),
        .inport_accept_o     (accept),
        .inport_ack_o        (ack),
        .inport_error_o      (err),
        .inport_read_data_o  (rdata),
`ifdef TCM_PMEM_AXI_STATS_EN
        .stat_wr_beats_o     (stat_wr),
        .stat_rd_beats_o     (stat_rd),
        .stat_err_o          (stat_err),
`endif
        .axi                 (axi)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } addr_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;
    typedef struct { logic is_rd; logic [31:0] data; logic err; } ack_t;

    addr_t       exp_aw_q[$];
    addr_t       exp_ar_q[$];
    wbeat_t      exp_w_q[$];
    ack_t        ack_q[$];
    logic [1:0]  bresp_q[$];
    logic [1:0]  rresp_q[$];
    logic [31:0] rdata_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ack_seen = 0;

    // Target-model knobs
    int aw_delay     = 0;
    int w_stall_pct  = 0;
    int r_gap_pct    = 0;
    int b_delay_pct  = 0;
    int stall_beat   = -1;
    int stall_left   = 0;
    int r_beat_limit = 1000;
    bit aw_after_w   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    task automatic abort(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL timeout %s: got no progress, required completion", name);
        summary();
        $finish;
    endtask

    // AXI4 target model: samples handshakes before the edge, drives after it.
    initial begin
        int    aw_wait, w_idx, aw_cnt, wl_cnt, since_wl, r_beat, r_len;
        bit    r_active, aw_hs, w_hs, b_hs, ar_hs, r_hs;
        addr_t ea;
        wbeat_t ew;
        aw_wait = 0; w_idx = 0; aw_cnt = 0; wl_cnt = 0; since_wl = 0;
        r_beat = 0; r_len = 0; r_active = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rid = 0; axi.rlast = 0;
        forever begin
            @(negedge clk);
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            b_hs  = axi.bvalid && axi.bready;
            ar_hs = axi.arvalid && axi.arready;
            r_hs  = axi.rvalid && axi.rready;
            if (!rst) begin
                if (aw_hs) begin
                    aw_cnt++;
                    aw_wait = 0;
                    if (exp_aw_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL aw_unexpected: got awaddr %h, required no AW", axi.awaddr);
                    end else begin
                        ea = exp_aw_q.pop_front();
                        chk("awaddr", axi.awaddr, ea.addr);
                        chk("awlen", 32'(axi.awlen), 32'(ea.len));
                        chk("awburst", 32'(axi.awburst), 32'd1);
                        chk("awid", 32'(axi.awid), 32'(TB_ID));
                    end
                end else if (axi.awvalid) begin
                    aw_wait++;
                end
                if (w_hs) begin
                    if (exp_w_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL w_unexpected: got wdata %h, required no W beat", axi.wdata);
                    end else begin
                        ew = exp_w_q.pop_front();
                        chk("wdata", axi.wdata, ew.data);
                        chk("wstrb", 32'(axi.wstrb), 32'(ew.strb));
                        chk("wlast", 32'(axi.wlast), 32'(ew.last));
                    end
                    if (axi.wlast) begin
                        wl_cnt++; w_idx = 0; since_wl = 0;
                    end else begin
                        w_idx++;
                    end
                end
                if (wl_cnt > 0) since_wl++;
                if (ar_hs) begin
                    if (exp_ar_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL ar_unexpected: got araddr %h, required no AR", axi.araddr);
                    end else begin
                        ea = exp_ar_q.pop_front();
                        chk("araddr", axi.araddr, ea.addr);
                        chk("arlen", 32'(axi.arlen), 32'(ea.len));
                        chk("arburst", 32'(axi.arburst), 32'd1);
                        chk("arid", 32'(axi.arid), 32'(TB_ID));
                    end
                    r_len = int'(axi.arlen); r_beat = 0; r_active = 1;
                end
                if (r_hs) begin
                    r_beat++;
                    if (r_beat > r_len) r_active = 0;
                end
            end
            @(posedge clk);
            #2;
            if (rst) begin
                aw_wait = 0; w_idx = 0; aw_cnt = 0; wl_cnt = 0; since_wl = 0; r_active = 0;
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.arready = 0;
                axi.rvalid = 0; axi.rlast = 0;
            end else begin
                axi.awready = axi.awvalid && (aw_wait >= aw_delay) &&
                              (!aw_after_w || (wl_cnt > 0 && since_wl >= 5));
                if (axi.wvalid && w_idx == stall_beat && stall_left > 0) begin
                    axi.wready = 0;
                    stall_left--;
                end else begin
                    axi.wready = ($urandom_range(99) >= w_stall_pct);
                end
                axi.arready = axi.arvalid && ($urandom_range(3) != 0);
                if (b_hs) axi.bvalid = 0;
                if (!axi.bvalid && aw_cnt > 0 && wl_cnt > 0 && bresp_q.size() > 0 &&
                    $urandom_range(99) >= b_delay_pct) begin
                    axi.bvalid = 1;
                    axi.bresp  = bresp_q.pop_front();
                    axi.bid    = 4'($urandom_range(15));
                    aw_cnt--; wl_cnt--;
                end
                if (r_hs) axi.rvalid = 0;
                if (!axi.rvalid && r_active && r_beat < r_beat_limit && rdata_q.size() > 0 &&
                    $urandom_range(99) >= r_gap_pct) begin
                    axi.rvalid = 1;
                    axi.rdata  = rdata_q.pop_front();
                    axi.rresp  = (rresp_q.size() > 0) ? rresp_q.pop_front() : 2'b00;
                    axi.rlast  = (r_beat == r_len);
                    axi.rid    = 4'($urandom_range(15));
                end
            end
        end
    end

    // Ack scoreboard and accept-blocking monitor
    initial begin
        ack_t ea;
        forever begin
            @(negedge clk);
            if (!rst && ack) begin
                ack_seen++;
                if (ack_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL ack_unexpected: got ack error=%b, required no ack", err);
                end else begin
                    ea = ack_q.pop_front();
                    chk(ea.is_rd ? "rd_ack_error" : "wr_ack_error", 32'(err), 32'(ea.err));
                    if (ea.is_rd) chk("rd_ack_data", rdata, ea.data);
                end
            end
            if (!rst && ((axi.wvalid && !axi.wready) || axi.bready || axi.rready || axi.arvalid))
                chk("accept_blocked", 32'(accept), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] w, input logic r, input logic [31:0] a,
                        input logic [7:0] l, input logic [31:0] d);
        int n;
        bit done;
        n = 0; done = 0;
        wr = w; rd = r; addr = a; len = l; wdata = d;
        while (!done) begin
            @(negedge clk);
            if (accept) done = 1;
            else if (++n > 2000) abort("send");
            @(posedge clk);
            #1;
        end
        wr = 4'd0; rd = 1'b0; addr = $urandom; len = 8'($urandom_range(255));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ack_q.size() != 0) begin
            @(negedge clk);
            if (++n > 4000) abort("wait_idle");
        end
        @(negedge clk);
        chk("accept_idle", 32'(accept), 32'd1);
        tick();
    endtask

    task automatic do_write(input logic [31:0] a, input int l, input logic [1:0] br, input int gap,
                            input bit fixed, input logic [31:0] base, input bit mix);
        logic [31:0] d;
        logic [3:0]  s;
        $display("write addr=%h len=%0d bresp=%0d", a, l, br);
        exp_aw_q.push_back('{a, 8'(l)});
        bresp_q.push_back(br);
        ack_q.push_back('{1'b0, 32'd0, br != 2'b00});
        for (int i = 0; i <= l; i++) begin
            d = fixed ? base + 32'(i) : $urandom;
            s = fixed ? 4'hF : 4'($urandom_range(15, 1));
            exp_w_q.push_back('{d, s, i == l});
            while ($urandom_range(99) < gap) tick();
            if (i == 0) send(s, mix, a, 8'(l), d);
            else        send(s, 1'b0, $urandom, 8'($urandom_range(255)), d);
        end
        wait_idle();
    endtask

    task automatic do_read(input logic [31:0] a, input int l, input int err_beat,
                           input bit incr, input bit rand_err);
        logic [31:0] d;
        logic [1:0]  rr;
        $display("read  addr=%h len=%0d err_beat=%0d", a, l, err_beat);
        exp_ar_q.push_back('{a, 8'(l)});
        for (int i = 0; i <= l; i++) begin
            d  = incr ? 32'(i) : $urandom;
            rr = (i == err_beat) ? 2'b11 :
                 ((rand_err && $urandom_range(99) < 8) ? 2'b10 : 2'b00);
            rdata_q.push_back(d);
            rresp_q.push_back(rr);
            ack_q.push_back('{1'b1, d, rr != 2'b00});
        end
        send(4'd0, 1'b1, a, 8'(l), 32'd0);
        wait_idle();
    endtask

    task automatic knobs(input int awd, input int wst, input int rg, input int bd);
        aw_delay = awd; w_stall_pct = wst; r_gap_pct = rg; b_delay_pct = bd;
    endtask

    initial begin
        #800000;
        abort("global_watchdog");
    end

    initial begin
        int base, n, l, t;
        rst = 1'b1; wr = 4'd0; rd = 1'b0; len = 8'd0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awvalid", 32'(axi.awvalid), 32'd0);
        chk("rst_wvalid", 32'(axi.wvalid), 32'd0);
        chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
        chk("rst_bready", 32'(axi.bready), 32'd0);
        chk("rst_rready", 32'(axi.rready), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_error", 32'(err), 32'd0);
        chk("rst_accept", 32'(accept), 32'd1);
        tick();
        rst = 1'b0;
        tick();

        knobs(0, 0, 0, 0);
        do_write(32'h0000_0100, 0, 2'b00, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);

        stall_beat = 1; stall_left = 3;
        do_write(32'h0000_0200, 3, 2'b00, 0, 1'b1, 32'h0000_1000, 1'b0);
        stall_beat = -1; stall_left = 0;

        aw_after_w = 1'b1;
        do_write(32'h0000_0300, 3, 2'b00, 0, 1'b0, 32'd0, 1'b0);
        aw_after_w = 1'b0;

        knobs(0, 0, 40, 0);
        do_read(32'h0000_2000, 7, -1, 1'b1, 1'b0);

        knobs(1, 20, 20, 30);
        do_write(32'h0000_0400, 1, 2'b10, 20, 1'b0, 32'd0, 1'b0);
        do_read(32'h0000_0500, 7, 3, 1'b0, 1'b0);

        // Reset in the middle of an 8-beat read
        $display("read  addr=00003000 len=7 reset after 3 beats");
        knobs(0, 0, 0, 0);
        r_beat_limit = 3;
        exp_ar_q.push_back('{32'h0000_3000, 8'd7});
        for (int i = 0; i < 8; i++) begin
            rdata_q.push_back(32'(100 + i));
            rresp_q.push_back(2'b00);
            ack_q.push_back('{1'b1, 32'(100 + i), 1'b0});
        end
        base = ack_seen;
        send(4'd0, 1'b1, 32'h0000_3000, 8'd7, 32'd0);
        n = 0;
        while (ack_seen < base + 3) begin
            @(negedge clk);
            if (++n > 500) abort("rst_mid_read");
        end
        repeat (2) @(negedge clk);
        chk("acks_before_rst", 32'(ack_seen - base), 32'd3);
        tick();
        rst = 1'b1;
        ack_q.delete(); rdata_q.delete(); rresp_q.delete();
        tick();
        rst = 1'b0;
        r_beat_limit = 1000;
        @(negedge clk);
        chk("postrst_rready", 32'(axi.rready), 32'd0);
        chk("postrst_arvalid", 32'(axi.arvalid), 32'd0);
        chk("postrst_ack", 32'(ack), 32'd0);
        chk("postrst_accept", 32'(accept), 32'd1);
        tick();
        do_write(32'h0000_0600, 2, 2'b00, 0, 1'b0, 32'd0, 1'b0);

        knobs(2, 25, 25, 25);
        do_write(32'h0001_0000, 255, 2'b00, 10, 1'b0, 32'd0, 1'b0);
        do_read(32'h0002_0000, 255, -1, 1'b0, 1'b1);

        for (t = 0; t < 40; t++) begin
            knobs($urandom_range(3), $urandom_range(50), $urandom_range(50), $urandom_range(60));
            aw_after_w = ($urandom_range(7) == 0);
            l = ($urandom_range(9) == 0) ? $urandom_range(255, 16) : $urandom_range(7);
            if ($urandom_range(1) == 1)
                do_write($urandom & 32'hFFFF_FFFC, l,
                         ($urandom_range(99) < 25) ? 2'($urandom_range(3, 1)) : 2'b00,
                         $urandom_range(30), 1'b0, 32'd0, ($urandom_range(4) == 0));
            else
                do_read($urandom & 32'hFFFF_FFFC, l, -1, 1'b0, 1'b1);
        end
        aw_after_w = 1'b0;

        repeat (5) @(negedge clk);
        chk("ack_q_empty", 32'(ack_q.size()), 32'd0);
        chk("aw_q_empty", 32'(exp_aw_q.size()), 32'd0);
        chk("w_q_empty", 32'(exp_w_q.size()), 32'd0);
        chk("ar_q_empty", 32'(exp_ar_q.size()), 32'd0);
        summary();
        $finish;
    end

endmodule
